// File: rtl/link_cmd_arbiter_if.sv
// Command-side and UART-side signal bundle for link_cmd_arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/UART side.
interface link_cmd_arbiter_if;
    logic [1:0] req;
    logic [7:0] cmd0;
    logic [7:0] cmd1;
    logic [1:0] done;
    logic [1:0] fail;
    logic       busy;
    logic [7:0] data_to_tx;
    logic       start_tx;
    logic       tx_busy;
    logic [7:0] data_received;
    logic       rx_done;
    logic       parity_error;
    logic [1:0] retry_cnt;

    modport slave (
        input  req, cmd0, cmd1, tx_busy, data_received, rx_done, parity_error,
        output done, fail, busy, data_to_tx, start_tx, retry_cnt
    );

    modport master (
        output req, cmd0, cmd1, tx_busy, data_received, rx_done, parity_error,
        input  done, fail, busy, data_to_tx, start_tx, retry_cnt
    );
endinterface

// File: rtl/link_cmd_arbiter.sv
// Two-requester round-robin command arbiter: sends a byte over UART, waits for its echo, retries and times out.
// Optional build macro LINK_PARITY_CHECK_EN rejects echoes flagged with a receiver parity error.
module link_cmd_arbiter #(
    parameter int TIMEOUT_CYCLES = 2400,
    parameter int MAX_RETRY      = 3
) (
    input logic               clk,
    input logic               reset,
    link_cmd_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SEND, TXWAIT, ECHO, RESP} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] TIMER_MAX  = 16'hFFFF;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] timer;
    logic [1:0]  retry_q;
    logic [7:0]  tx_byte;
    logic        rr_ptr;
    logic        gnt;
    logic        ok;

    logic        gnt_sel;
    logic        timer_exp;
    logic        echo_hit;
    logic        echo_miss;
    logic        attempt_fail;
    logic        can_retry;
    logic        parity_bad;

`ifdef LINK_PARITY_CHECK_EN
    assign parity_bad = bus.parity_error;
`else
    logic unused_parity;
    assign parity_bad    = 1'b0;
    assign unused_parity = bus.parity_error;
`endif

    // Prefer the requester not served last; fall back to the other one.
    assign gnt_sel = bus.req[rr_ptr] ? rr_ptr : ~rr_ptr;

    always_comb begin
        timer_exp    = (timer == TIMER_LAST);
        can_retry    = (int'(retry_q) < MAX_RETRY);
        echo_hit     = (state == ECHO) && bus.rx_done && !parity_bad &&
                       (bus.data_received == tx_byte);
        echo_miss    = (state == ECHO) && bus.rx_done && !echo_hit;
        // An echo arriving in the same cycle as expiry takes priority over the timeout.
        attempt_fail = echo_miss ||
                       ((state == ECHO) && !bus.rx_done && timer_exp) ||
                       ((state == SEND) && !bus.tx_busy && timer_exp);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (|bus.req) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (bus.tx_busy) begin
                    state_nxt = TXWAIT;
                end else if (attempt_fail && !can_retry) begin
                    state_nxt = RESP;
                end
            end
            TXWAIT: begin
                if (!bus.tx_busy) begin
                    state_nxt = ECHO;
                end
            end
            ECHO: begin
                if (echo_hit) begin
                    state_nxt = RESP;
                end else if (attempt_fail) begin
                    state_nxt = can_retry ? SEND : RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            retry_q <= '0;
            tx_byte <= '0;
            rr_ptr  <= 1'b0;
            gnt     <= 1'b0;
            ok      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        gnt     <= gnt_sel;
                        rr_ptr  <= ~gnt_sel;
                        tx_byte <= gnt_sel ? bus.cmd1 : bus.cmd0;
                        retry_q <= '0;
                        timer   <= '0;
                        ok      <= 1'b0;
                    end
                end
                SEND, ECHO: begin
                    if (attempt_fail) begin
                        if (can_retry) begin
                            retry_q <= retry_q + 2'd1;
                            timer   <= '0;
                        end else begin
                            ok <= 1'b0;
                        end
                    end else if (echo_hit) begin
                        ok <= 1'b1;
                    end else if (timer != TIMER_MAX) begin
                        timer <= timer + 16'd1;
                    end
                end
                TXWAIT: begin
                    if (!bus.tx_busy) begin
                        timer <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.start_tx = (state == SEND);
        bus.busy     = (state != IDLE);
        bus.done     = 2'b00;
        bus.fail     = 2'b00;
        if (state == RESP) begin
            if (ok) begin
                bus.done = gnt ? 2'b10 : 2'b01;
            end else begin
                bus.fail = gnt ? 2'b10 : 2'b01;
            end
        end
    end

    assign bus.data_to_tx = tx_byte;
    assign bus.retry_cnt  = retry_q;

endmodule

// File: tb/tb_link_cmd_arbiter.sv
// Scoreboard bench for link_cmd_arbiter with a UART transmitter/echo model.
module tb_link_cmd_arbiter;
    localparam int TO = 100;
    localparam int MR = 3;

`ifdef LINK_PARITY_CHECK_EN
    localparam logic [1:0] PAR_RETRY = 2'd1;
    localparam logic [7:0] PAR_NTX   = 8'd2;
`else
    localparam logic [1:0] PAR_RETRY = 2'd0;
    localparam logic [7:0] PAR_NTX   = 8'd1;
`endif

    logic clk;
    logic reset;

    link_cmd_arbiter_if bus();

    link_cmd_arbiter #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic       silent;
        logic       par;
        logic [7:0] data;
        logic [7:0] want_tx;
    } echo_t;

    typedef struct packed {
        logic [1:0] done;
        logic [1:0] fail;
        logic [1:0] retry;
        logic [7:0] ntx;
    } exp_t;

    echo_t echo_q[$];
    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_tx     = 0;
    int    tx_base  = 0;

    initial begin
        clk = 1'b0;
        forever #21 clk = ~clk;
    end

    initial begin
        #(42 * 60000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic echo_t mk_echo(input logic silent, input logic par,
                                      input logic [7:0] data, input logic [7:0] want_tx);
        echo_t e;
        e.silent  = silent;
        e.par     = par;
        e.data    = data;
        e.want_tx = want_tx;
        return e;
    endfunction

    task automatic push_exp(input logic [1:0] d, input logic [1:0] f,
                            input logic [1:0] r, input logic [7:0] ntx);
        exp_t x;
        x.done  = d;
        x.fail  = f;
        x.retry = r;
        x.ntx   = ntx;
        exp_q.push_back(x);
    endtask

    // Transmitter accepts start_tx, stays busy 3 cycles, then the receiver echoes per plan.
    initial begin : tx_model
        echo_t e;
        bus.tx_busy       = 1'b0;
        bus.rx_done       = 1'b0;
        bus.data_received = 8'h00;
        bus.parity_error  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset && bus.start_tx && !bus.tx_busy) begin
                n_tx++;
                if (echo_q.size() > 0) begin
                    e = echo_q.pop_front();
                    check_eq("tx_data", 32'(bus.data_to_tx), 32'(e.want_tx));
                end else begin
                    e = '0;
                    e.silent = 1'b1;
                end
                bus.tx_busy = 1'b1;
                repeat (3) @(negedge clk);
                bus.tx_busy = 1'b0;
                repeat (2) @(negedge clk);
                if (!e.silent) begin
                    bus.data_received = e.data;
                    bus.parity_error  = e.par;
                    bus.rx_done       = 1'b1;
                    @(negedge clk);
                    bus.rx_done      = 1'b0;
                    bus.parity_error = 1'b0;
                end
            end
        end
    end

    initial begin : monitor
        exp_t x;
        forever begin
            @(negedge clk);
            if ((bus.done | bus.fail) != 2'b00) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_resp", 32'({bus.done, bus.fail}), 32'd0);
                end else begin
                    x = exp_q.pop_front();
                    check_eq("done",      32'(bus.done),      32'(x.done));
                    check_eq("fail",      32'(bus.fail),      32'(x.fail));
                    check_eq("retry_cnt", 32'(bus.retry_cnt), 32'(x.retry));
                    check_eq("num_tx",    32'(n_tx - tx_base), 32'(x.ntx));
                end
                tx_base = n_tx;
                @(negedge clk);
                check_eq("pulse_len", 32'({bus.done, bus.fail}), 32'd0);
            end
        end
    end

    task automatic run_txn(input logic [1:0] r, input logic [7:0] c0, input logic [7:0] c1,
                           input logic scramble, input int budget);
        int cyc;
        cyc      = 0;
        bus.cmd0 = c0;
        bus.cmd1 = c1;
        bus.req  = r;
        while (bus.req != 2'b00 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (scramble && cyc == 3) begin
                bus.cmd0 = ~c0;
                bus.cmd1 = ~c1;
            end
            bus.req = bus.req & ~(bus.done | bus.fail);
        end
        check_eq("txn_complete", 32'(bus.req), 32'd0);
        bus.req = 2'b00;
        echo_q.delete();
        @(negedge clk);
        check_eq("busy_after", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},     32'(bus.busy),       32'd0);
        check_eq({tag, "_start_tx"}, 32'(bus.start_tx),   32'd0);
        check_eq({tag, "_done"},     32'(bus.done),       32'd0);
        check_eq({tag, "_fail"},     32'(bus.fail),       32'd0);
        check_eq({tag, "_data"},     32'(bus.data_to_tx), 32'd0);
        check_eq({tag, "_retry"},    32'(bus.retry_cnt),  32'd0);
    endtask

    initial begin : main
        int cyc;
        bus.req  = 2'b00;
        bus.cmd0 = 8'h00;
        bus.cmd1 = 8'h00;
        reset    = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single clean transaction; cmd0 changes after grant must not leak through.
        echo_q.push_back(mk_echo(1'b0, 1'b0, 8'hEE, 8'hEE));
        push_exp(2'b01, 2'b00, 2'd0, 8'd1);
        run_txn(2'b01, 8'hEE, 8'h00, 1'b1, 200);

        // Two mismatched echoes, then a match.
        echo_q.push_back(mk_echo(1'b0, 1'b0, 8'h11, 8'hEE));
        echo_q.push_back(mk_echo(1'b0, 1'b0, 8'h11, 8'hEE));
        echo_q.push_back(mk_echo(1'b0, 1'b0, 8'hEE, 8'hEE));
        push_exp(2'b01, 2'b00, 2'd2, 8'd3);
        run_txn(2'b01, 8'hEE, 8'h00, 1'b0, 400);

        // No echo at all: four attempts, then fail.
        for (int i = 0; i < 4; i++) begin
            echo_q.push_back(mk_echo(1'b1, 1'b0, 8'h00, 8'hC3));
        end
        push_exp(2'b00, 2'b10, 2'd3, 8'd4);
        run_txn(2'b10, 8'h00, 8'hC3, 1'b1, 1000);

        // Parity-flagged matching echo followed by a clean one.
        echo_q.push_back(mk_echo(1'b0, 1'b1, 8'hEE, 8'hEE));
        echo_q.push_back(mk_echo(1'b0, 1'b0, 8'hEE, 8'hEE));
        push_exp(2'b01, 2'b00, PAR_RETRY, PAR_NTX);
        run_txn(2'b01, 8'hEE, 8'h00, 1'b0, 400);

        // Reset while waiting for an echo: no response, outputs back to reset values.
        echo_q.push_back(mk_echo(1'b1, 1'b0, 8'h00, 8'h3C));
        bus.cmd0 = 8'h3C;
        bus.req  = 2'b01;
        cyc = 0;
        while (n_tx == tx_base && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("rst_scn_tx", 32'(n_tx - tx_base), 32'd1);
        repeat (20) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        bus.req = 2'b00;
        echo_q.delete();
        @(negedge clk);
        reset   = 1'b1;
        tx_base = n_tx;
        repeat (2) @(negedge clk);

        // Both requesting right after reset: requester 0 first, then 1.
        echo_q.push_back(mk_echo(1'b0, 1'b0, 8'h55, 8'h55));
        echo_q.push_back(mk_echo(1'b0, 1'b0, 8'hC3, 8'hC3));
        push_exp(2'b01, 2'b00, 2'd0, 8'd1);
        push_exp(2'b10, 2'b00, 2'd0, 8'd1);
        run_txn(2'b11, 8'h55, 8'hC3, 1'b0, 400);

        repeat (5) @(negedge clk);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
